tt_lock_sequencer: RTL

Synchronous controller for the switch-programmable combination lock datapath. It compares a 3-bit code word against a stored code on an "enter" strobe and sequences the lock through open, relock, failed-attempt counting and alarm lockout. It allows the stored code to be reprogrammed only while the lock is open. It replaces the ad-hoc flop/gate chain between the code switches and the lock/alarm outputs with one clocked FSM on the project clock.

---
 rtl/tt_lock_sequencer.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tt_lock_sequencer.sv
// Combination lock controller: code compare, open/relock, fail counting.
// Optional alarm lockout after MAX_TRIES wrong entries: LOCK_LOCKOUT_EN.
module tt_lock_sequencer #(
  parameter int               CODE_W         = 3,
  parameter logic [CODE_W-1:0] RESET_CODE    = 3'b101,
  parameter int               OPEN_CYCLES    = 16,
  parameter int               LOCKOUT_CYCLES = 64,
  parameter int               MAX_TRIES      = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [CODE_W-1:0]              code_in,
  input  logic                           enter,
  input  logic                           prog,
  output logic                           unlocked,
  output logic                           alarm,
  output logic                           denied,
  output logic                           prog_ack,
  output logic [$clog2(MAX_TRIES+1)-1:0] fail_cnt,
  output logic [1:0]                     state
);

  localparam int FW   = $clog2(MAX_TRIES + 1);
  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ?
                        OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [FW-1:0] MAX_F   = FW'(MAX_TRIES);
  localparam logic [TW-1:0] OPEN_LD = TW'(OPEN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    OPEN    = 2'd1,
    LOCKOUT = 2'd2
  } st_t;

  st_t               st;
  logic [TW-1:0]     timer;
  logic [CODE_W-1:0] stored;
  logic [FW-1:0]     fail;
  logic              enter_q;
  logic              prog_q;
  logic              enter_rise;
  logic              prog_rise;

  assign enter_rise = enter & ~enter_q;
  assign prog_rise  = prog & ~prog_q;
  assign fail_cnt   = fail;
  assign state      = st;

`ifdef LOCK_LOCKOUT_EN
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYCLES - 1);

  logic [FW-1:0] fail_nx;
  logic          alarm_r;

  assign fail_nx = fail + 1'b1;
  assign alarm   = alarm_r;

  // Lock FSM with lockout: state, timer, stored code, counters, outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      timer    <= '0;
      stored   <= RESET_CODE;
      fail     <= '0;
      enter_q  <= enter;
      prog_q   <= prog;
      unlocked <= 1'b0;
      alarm_r  <= 1'b0;
      denied   <= 1'b0;
      prog_ack <= 1'b0;
    end else begin
      enter_q  <= enter;
      prog_q   <= prog;
      denied   <= 1'b0;
      prog_ack <= 1'b0;
      case (st)
        IDLE: begin
          if (enter_rise) begin
            if (code_in == stored) begin
              st       <= OPEN;
              timer    <= OPEN_LD;
              fail     <= '0;
              unlocked <= 1'b1;
            end else begin
              denied <= 1'b1;
              fail   <= fail_nx;
              if (fail_nx == MAX_F) begin
                st      <= LOCKOUT;
                timer   <= LOCK_LD;
                alarm_r <= 1'b1;
              end
            end
          end
        end
        OPEN: begin
          if (prog_rise) begin
            stored   <= code_in;
            prog_ack <= 1'b1;
            st       <= IDLE;
            timer    <= '0;
            unlocked <= 1'b0;
          end else if (enter_rise || timer == '0) begin
            st       <= IDLE;
            timer    <= '0;
            unlocked <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        LOCKOUT: begin
          if (timer == '0) begin
            st      <= IDLE;
            fail    <= '0;
            alarm_r <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          st       <= IDLE;
          timer    <= '0;
          unlocked <= 1'b0;
          alarm_r  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign alarm = 1'b0;

  // Lock FSM without lockout: wrong entries saturate the fail counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      timer    <= '0;
      stored   <= RESET_CODE;
      fail     <= '0;
      enter_q  <= enter;
      prog_q   <= prog;
      unlocked <= 1'b0;
      denied   <= 1'b0;
      prog_ack <= 1'b0;
    end else begin
      enter_q  <= enter;
      prog_q   <= prog;
      denied   <= 1'b0;
      prog_ack <= 1'b0;
      case (st)
        IDLE: begin
          if (enter_rise) begin
            if (code_in == stored) begin
              st       <= OPEN;
              timer    <= OPEN_LD;
              fail     <= '0;
              unlocked <= 1'b1;
            end else begin
              denied <= 1'b1;
              if (fail != MAX_F)
                fail <= fail + 1'b1;
            end
          end
        end
        OPEN: begin
          if (prog_rise) begin
            stored   <= code_in;
            prog_ack <= 1'b1;
            st       <= IDLE;
            timer    <= '0;
            unlocked <= 1'b0;
          end else if (enter_rise || timer == '0) begin
            st       <= IDLE;
            timer    <= '0;
            unlocked <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end
        default: begin
          st       <= IDLE;
          timer    <= '0;
          unlocked <= 1'b0;
        end
      endcase
    end
  end
`endif

endmodule
